// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_stall_ctrl_pkg;

  // Controller state, 2-bit encoding visible on ctrl_state for debug
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH_PEND = 2'd2,
    ERROR      = 2'd3
  } ctrl_state_t;

  // Consecutive stalled cycles tolerated before the memory timeout is flagged
  localparam int DEFAULT_WAIT_TIMEOUT = 64;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall sources in, pipeline freeze/flush/bubble controls out
interface pipe_stall_ctrl_if;

  logic       hazard_detected;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       freeze_all;
  logic       freeze_front;
  logic       flush;
  logic       bubble;
  logic       mem_timeout;
  logic [1:0] ctrl_state;

  // Pipeline side: raises stall sources, obeys the controls
  modport master (
    output hazard_detected, branch_taken, mem_req, mem_ready,
    input  freeze_all, freeze_front, flush, bubble, mem_timeout, ctrl_state
  );

  // Controller side
  modport slave (
    input  hazard_detected, branch_taken, mem_req, mem_ready,
    output freeze_all, freeze_front, flush, bubble, mem_timeout, ctrl_state
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// rtl/pipe_stall_ctrl_sat_counter.sv - saturating up-counter with enable and synchronous clear
module pipe_stall_ctrl_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Clear wins over enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline freeze/flush/bubble arbiter; optional perf counters under PIPE_STALL_PERF_EN
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT,
  parameter int WAIT_CNT_W   = 8,
  parameter int PERF_CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_stall_ctrl_if.slave      bus
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_hazard_cycles,
  output logic [PERF_CNT_W-1:0] perf_mem_cycles,
  output logic [PERF_CNT_W-1:0] perf_flushes
`endif
);

  if ((PERF_CNT_W < 1) || ((2 ** WAIT_CNT_W) <= WAIT_TIMEOUT)) begin : g_bad_param
    $error("pipe_stall_ctrl: WAIT_CNT_W too narrow for WAIT_TIMEOUT or PERF_CNT_W < 1");
  end

  localparam logic [WAIT_CNT_W:0] TIMEOUT_CNT = (WAIT_CNT_W + 1)'(WAIT_TIMEOUT);

  ctrl_state_t           state;
  ctrl_state_t           state_next;
  logic                  pend_flush;
  logic                  pend_next;
  logic                  timeout_q;
  logic                  timeout_next;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W:0]   wait_cnt_inc;
  logic                  mem_stall;
  logic                  flush_raw;
  logic                  hit_timeout;
  logic                  freeze_all_o;
  logic                  freeze_front_o;
  logic                  flush_o;
  logic                  bubble_o;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign flush_raw = ~mem_stall & (bus.branch_taken | pend_flush);

  // wait_cnt holds the number of stalled cycles before this one, so the
  // incremented value counts the current stalled cycle as well
  assign wait_cnt_inc = {1'b0, wait_cnt} + 1'b1;
  assign hit_timeout  = mem_stall && (wait_cnt_inc >= TIMEOUT_CNT);

  // A flush kills the dependent instruction, so it suppresses the hazard stall;
  // everything is forced low while rst is held
  assign freeze_all_o   = ~rst & mem_stall;
  assign flush_o        = ~rst & flush_raw;
  assign freeze_front_o = ~rst & (mem_stall | (bus.hazard_detected & ~flush_raw));
  assign bubble_o       = ~rst & ~mem_stall & bus.hazard_detected & ~flush_raw;

  assign bus.freeze_all   = freeze_all_o;
  assign bus.flush        = flush_o;
  assign bus.freeze_front = freeze_front_o;
  assign bus.bubble       = bubble_o;
  assign bus.mem_timeout  = timeout_q;
  assign bus.ctrl_state   = state;

  // Counts consecutive stalled cycles; any unstalled cycle restarts it
  pipe_stall_ctrl_sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_stall),
    .clr   (~mem_stall),
    .count (wait_cnt)
  );

  // State, deferred-flush flag and sticky timeout register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state      <= state_next;
      pend_flush <= pend_next;
      timeout_q  <= timeout_next;
    end
  end

  // Next state: a taken branch seen under a freeze is held until the freeze
  // releases, then delivered once as a flush
  always_comb begin
    state_next   = state;
    pend_next    = pend_flush;
    timeout_next = timeout_q;

    if (mem_stall && bus.branch_taken) begin
      pend_next = 1'b1;
    end else if (!mem_stall) begin
      pend_next = 1'b0;
    end

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_next = bus.branch_taken ? FLUSH_PEND : MEM_WAIT;
        end
      end
      MEM_WAIT, FLUSH_PEND: begin
        if (!mem_stall) begin
          state_next = RUN;
        end else if (hit_timeout) begin
          state_next   = ERROR;
          timeout_next = 1'b1;
        end else if (bus.branch_taken) begin
          state_next = FLUSH_PEND;
        end
      end
      ERROR: begin
        state_next   = ERROR;
        timeout_next = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

`ifdef PIPE_STALL_PERF_EN
  pipe_stall_ctrl_sat_counter #(.W(PERF_CNT_W)) u_perf_hazard (
    .clk   (clk),
    .rst   (rst),
    .en    (bubble_o),
    .clr   (1'b0),
    .count (perf_hazard_cycles)
  );

  pipe_stall_ctrl_sat_counter #(.W(PERF_CNT_W)) u_perf_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (freeze_all_o),
    .clr   (1'b0),
    .count (perf_mem_cycles)
  );

  pipe_stall_ctrl_sat_counter #(.W(PERF_CNT_W)) u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_o),
    .clr   (1'b0),
    .count (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl; perf checks under PIPE_STALL_PERF_EN
module tb_pipe_stall_ctrl;

  logic clk;
  logic rst;

  pipe_stall_ctrl_if bus ();

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] perf_hazard_cycles;
  logic [31:0] perf_mem_cycles;
  logic [31:0] perf_flushes;
`endif

  pipe_stall_ctrl #(
    .WAIT_TIMEOUT (4),
    .WAIT_CNT_W   (8),
    .PERF_CNT_W   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_STALL_PERF_EN
    ,
    .perf_hazard_cycles (perf_hazard_cycles),
    .perf_mem_cycles    (perf_mem_cycles),
    .perf_flushes       (perf_flushes)
`endif
  );

  typedef struct {
    int         id;
    logic       fa;
    logic       ff;
    logic       fl;
    logic       bu;
    logic       to;
    logic [1:0] st;
    logic [7:0] wc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec %0d %s: got %0h expected %0h", id, name, act, req);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue what the outputs must be
  task automatic step(input logic r, input logic h, input logic b, input logic q, input logic y,
                      input logic fa, input logic ff, input logic fl, input logic bu, input logic to,
                      input logic [1:0] st, input logic [7:0] wc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.hazard_detected = h;
    bus.branch_taken    = b;
    bus.mem_req         = q;
    bus.mem_ready       = y;
    e.id = vec_id;
    e.fa = fa;
    e.ff = ff;
    e.fl = fl;
    e.bu = bu;
    e.to = to;
    e.st = st;
    e.wc = wc;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.id, "freeze_all",   {31'b0, bus.freeze_all},   {31'b0, mon_e.fa});
      check(mon_e.id, "freeze_front", {31'b0, bus.freeze_front}, {31'b0, mon_e.ff});
      check(mon_e.id, "flush",        {31'b0, bus.flush},        {31'b0, mon_e.fl});
      check(mon_e.id, "bubble",       {31'b0, bus.bubble},       {31'b0, mon_e.bu});
      check(mon_e.id, "mem_timeout",  {31'b0, bus.mem_timeout},  {31'b0, mon_e.to});
      check(mon_e.id, "ctrl_state",   {30'b0, bus.ctrl_state},   {30'b0, mon_e.st});
      check(mon_e.id, "wait_cnt",     {24'b0, dut.wait_cnt},     {24'b0, mon_e.wc});
    end
  end

  initial begin
    rst                 = 1'b1;
    bus.hazard_detected = 1'b0;
    bus.branch_taken    = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;

    //    r h b q y   fa ff fl bu to  st wc
    // reset state
    step(1,0,0,0,0,  0,0,0,0,0,  0,0);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // hazard only
    step(0,1,0,0,0,  0,1,0,1,0,  0,0);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // hazard together with branch: flush wins
    step(0,1,1,0,0,  0,0,1,0,0,  0,0);
    // mem_ready in the same cycle as mem_req: no stall, no state change
    step(0,0,0,1,1,  0,0,0,0,0,  0,0);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // deferred flush across a 3-cycle freeze, hazard ignored while frozen
    step(0,0,1,1,0,  1,1,0,0,0,  0,0);
    step(0,0,0,1,0,  1,1,0,0,0,  2,1);
    step(0,1,0,1,0,  1,1,0,0,0,  2,2);
    step(0,0,0,1,1,  0,0,1,0,0,  2,3);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // hazard re-evaluated once the freeze releases
    step(0,1,0,1,0,  1,1,0,0,0,  0,0);
    step(0,1,0,0,0,  0,1,0,1,0,  1,1);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // branch arriving during MEM_WAIT, hazard suppressed by the delivered flush
    step(0,0,0,1,0,  1,1,0,0,0,  0,0);
    step(0,0,1,1,0,  1,1,0,0,0,  1,1);
    step(0,1,0,1,1,  0,0,1,0,0,  2,2);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // asynchronous reset in the middle of MEM_WAIT
    step(0,0,0,1,0,  1,1,0,0,0,  0,0);
    step(0,0,0,1,0,  1,1,0,0,0,  1,1);
    step(1,0,0,1,0,  0,0,0,0,0,  0,0);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);
    // timeout after the 4th stalled cycle, flag sticky after mem_ready
    step(0,0,0,1,0,  1,1,0,0,0,  0,0);
    step(0,0,0,1,0,  1,1,0,0,0,  1,1);
    step(0,0,0,1,0,  1,1,0,0,0,  1,2);
    step(0,0,0,1,0,  1,1,0,0,0,  1,3);
    step(0,0,0,1,0,  1,1,0,0,1,  3,4);
    step(0,0,0,1,1,  0,0,0,0,1,  3,5);
    step(0,1,0,0,0,  0,1,0,1,1,  3,0);
    // stall again in ERROR up to wait_cnt = 5, then reset mid-wait
    step(0,0,0,1,0,  1,1,0,0,1,  3,0);
    step(0,0,0,1,0,  1,1,0,0,1,  3,1);
    step(0,0,0,1,0,  1,1,0,0,1,  3,2);
    step(0,0,0,1,0,  1,1,0,0,1,  3,3);
    step(0,0,0,1,0,  1,1,0,0,1,  3,4);
    step(0,0,0,1,0,  1,1,0,0,1,  3,5);
    step(1,0,0,1,0,  0,0,0,0,0,  0,0);
    // 2 hazard cycles, 3 stall cycles, 1 flush
    step(0,1,0,0,0,  0,1,0,1,0,  0,0);
    step(0,1,0,0,0,  0,1,0,1,0,  0,0);
    step(0,0,0,1,0,  1,1,0,0,0,  0,0);
    step(0,0,0,1,0,  1,1,0,0,0,  1,1);
    step(0,0,0,1,0,  1,1,0,0,0,  1,2);
    step(0,0,1,1,1,  0,0,1,0,0,  1,3);
    step(0,0,0,0,0,  0,0,0,0,0,  0,0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

`ifdef PIPE_STALL_PERF_EN
    check(vec_id, "perf_hazard_cycles", perf_hazard_cycles, 32'd2);
    check(vec_id, "perf_mem_cycles",    perf_mem_cycles,    32'd3);
    check(vec_id, "perf_flushes",       perf_flushes,       32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
